// File: rtl/ensm_pin_sequencer.sv
// ENSM pin timing guard for the AD9361 ENABLE/TXNRX pads.
// Synchronises GPIO requests, enforces setup/high/hold timing, tracks violations.
module ensm_pin_sequencer #(
   parameter int SYNC_STAGES     = 2,
   parameter int SETUP_CYCLES    = 4,
   parameter int MIN_HIGH_CYCLES = 2,
   parameter int HOLD_CYCLES     = 4,
   parameter int CNT_WIDTH       = 8
) (
   input  logic       axi_aclk,
   input  logic       axi_aresetn,
   input  logic       up_enable,
   input  logic       up_txnrx,
   input  logic       viol_clr,
   output logic       enable,
   output logic       txnrx,
   output logic       busy,
   output logic       viol_flag,
   output logic [7:0] viol_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_HOLD
   } state_t;

   localparam logic [CNT_WIDTH-1:0] SETUP_LD = CNT_WIDTH'(SETUP_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] HIGH_LD  = CNT_WIDTH'(MIN_HIGH_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] HOLD_LD  = CNT_WIDTH'(HOLD_CYCLES - 1);

   logic req_en;
   logic req_tx;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign req_en = up_enable;
         assign req_tx = up_txnrx;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] en_sync_q;
         logic [SYNC_STAGES-1:0] tx_sync_q;

         // Shift both GPIO requests through the synchroniser chain
         always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
            if (!axi_aresetn) begin
               en_sync_q <= '0;
               tx_sync_q <= '0;
            end else begin
               en_sync_q[0] <= up_enable;
               tx_sync_q[0] <= up_txnrx;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  en_sync_q[i] <= en_sync_q[i-1];
                  tx_sync_q[i] <= tx_sync_q[i-1];
               end
            end
         end

         assign req_en = en_sync_q[SYNC_STAGES-1];
         assign req_tx = tx_sync_q[SYNC_STAGES-1];
      end
   endgenerate

   state_t               state_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 enable_q;
   logic                 txnrx_q;
   logic                 busy_q;

   // Pin sequencing FSM; all pin drives are registered with the state
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         enable_q <= 1'b0;
         txnrx_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               txnrx_q <= req_tx;
               if (req_en) begin
                  cnt_q   <= SETUP_LD;
                  state_q <= S_SETUP;
                  busy_q  <= 1'b1;
               end
            end
            S_SETUP: begin
               if (!req_en) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (cnt_q == '0) begin
                  enable_q <= 1'b1;
                  cnt_q    <= HIGH_LD;
                  state_q  <= S_HIGH;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_HIGH: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (!req_en) begin
                  enable_q <= 1'b0;
                  cnt_q    <= HOLD_LD;
                  state_q  <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (cnt_q == '0) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               enable_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   logic       mis_q;
   logic       mismatch;
   logic       viol;
   logic       viol_flag_q;
   logic       viol_flag_d;
   logic [7:0] viol_count_q;
   logic [7:0] viol_count_d;

   assign mismatch = (state_q == S_HIGH) && (req_tx != txnrx_q);
   assign viol     = mismatch && !mis_q;

   // A new violation outranks a simultaneous clear and counts as the first
   always_comb begin
      viol_flag_d  = viol_flag_q;
      viol_count_d = viol_count_q;
      if (viol) begin
         viol_flag_d = 1'b1;
         if (viol_clr) begin
            viol_count_d = 8'd1;
         end else if (viol_count_q != 8'hFF) begin
            viol_count_d = viol_count_q + 8'd1;
         end
      end else if (viol_clr) begin
         viol_flag_d  = 1'b0;
         viol_count_d = 8'd0;
      end
   end

   // Violation state: episode edge detector, sticky flag, saturating count
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         mis_q        <= 1'b0;
         viol_flag_q  <= 1'b0;
         viol_count_q <= 8'd0;
      end else begin
         mis_q        <= mismatch;
         viol_flag_q  <= viol_flag_d;
         viol_count_q <= viol_count_d;
      end
   end

   assign enable     = enable_q;
   assign txnrx      = txnrx_q;
   assign busy       = busy_q;
   assign viol_flag  = viol_flag_q;
   assign viol_count = viol_count_q;

endmodule

// File: tb/tb_ensm_pin_sequencer.sv
// Bench for ensm_pin_sequencer at default parameters.
// Expected pin values are queued with their due edge and checked on negedges.
module tb_ensm_pin_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       up_en = 1'b0;
   logic       up_tx = 1'b0;
   logic       clr = 1'b0;
   logic       enable;
   logic       txnrx;
   logic       busy;
   logic       viol_flag;
   logic [7:0] viol_count;

   int total = 0;
   int bad = 0;
   int ecnt = 0;

   localparam int SG_EN  = 0;
   localparam int SG_TX  = 1;
   localparam int SG_BSY = 2;
   localparam int SG_FLG = 3;
   localparam int SG_CNT = 4;

   typedef struct {
      int    cyc;
      int    sig;
      int    val;
      string tag;
   } exp_t;

   exp_t sb[$];

   ensm_pin_sequencer dut (
      .axi_aclk   (clk),
      .axi_aresetn(rst_n),
      .up_enable  (up_en),
      .up_txnrx   (up_tx),
      .viol_clr   (clr),
      .enable     (enable),
      .txnrx      (txnrx),
      .busy       (busy),
      .viol_flag  (viol_flag),
      .viol_count (viol_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, ecnt);
      end
   endtask

   task automatic expect_at(input int rel, input int sig,
                            input int val, input string tag);
      exp_t e;
      e.cyc = ecnt + rel;
      e.sig = sig;
      e.val = val;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int sample(input int sig);
      case (sig)
         SG_EN:   return int'(enable);
         SG_TX:   return int'(txnrx);
         SG_BSY:  return int'(busy);
         SG_FLG:  return int'(viol_flag);
         default: return int'(viol_count);
      endcase
   endfunction

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == ecnt) begin
            chk(sb[i].tag, sample(sb[i].sig), sb[i].val);
            sb.delete(i);
         end
      end
   end

   initial begin
      tick(3);
      chk("rst_en", int'(enable), 0);
      chk("rst_tx", int'(txnrx), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_flag", int'(viol_flag), 0);
      chk("rst_cnt", int'(viol_count), 0);
      rst_n = 1'b1;
      tick(3);

      // basic rise, then early withdrawal -> exactly MIN_HIGH high
      up_tx = 1'b1;
      up_en = 1'b1;
      expect_at(2, SG_TX, 0, "b_tx_e2");
      expect_at(3, SG_TX, 1, "b_tx_e3");
      expect_at(2, SG_BSY, 0, "b_busy_e2");
      expect_at(3, SG_BSY, 1, "b_busy_e3");
      expect_at(6, SG_EN, 0, "b_en_e6");
      expect_at(7, SG_EN, 1, "b_en_e7");
      expect_at(8, SG_EN, 1, "s_en_e8");
      expect_at(9, SG_EN, 0, "s_en_e9");
      expect_at(12, SG_BSY, 1, "s_busy_e12");
      expect_at(13, SG_BSY, 0, "s_busy_e13");
      expect_at(13, SG_TX, 1, "s_tx_e13");
      tick(5);
      up_en = 1'b0;
      tick(9);

      // abort during SETUP
      up_en = 1'b1;
      for (int k = 1; k <= 10; k++) expect_at(k, SG_EN, 0, "a_en_low");
      expect_at(3, SG_BSY, 1, "a_busy_e3");
      expect_at(5, SG_BSY, 1, "a_busy_e5");
      expect_at(6, SG_BSY, 0, "a_busy_e6");
      expect_at(10, SG_FLG, 0, "a_flag");
      expect_at(10, SG_CNT, 0, "a_cnt");
      tick(3);
      up_en = 1'b0;
      tick(8);

      // violations while enable is high
      up_en = 1'b1;
      expect_at(7, SG_EN, 1, "v_en_e7");
      expect_at(10, SG_CNT, 0, "v_cnt_e10");
      expect_at(11, SG_CNT, 1, "v_cnt_e11");
      expect_at(11, SG_TX, 1, "v_tx_e11");
      expect_at(15, SG_TX, 1, "v_tx_e15");
      expect_at(19, SG_CNT, 2, "v_cnt_e19");
      expect_at(22, SG_CNT, 2, "v_cnt_e22");
      expect_at(22, SG_FLG, 1, "v_flag_e22");
      expect_at(22, SG_TX, 1, "v_tx_e22");
      expect_at(29, SG_CNT, 1, "v_clrwin_cnt");
      expect_at(29, SG_FLG, 1, "v_clrwin_flag");
      expect_at(31, SG_CNT, 1, "v_cnt_e31");
      expect_at(32, SG_CNT, 0, "v_clr_cnt");
      expect_at(32, SG_FLG, 0, "v_clr_flag");
      expect_at(34, SG_EN, 1, "v_en_e34");
      expect_at(35, SG_EN, 0, "v_fall_e35");
      expect_at(38, SG_BSY, 1, "v_busy_e38");
      expect_at(39, SG_BSY, 0, "v_busy_e39");
      expect_at(39, SG_TX, 1, "v_tx_frozen");
      expect_at(40, SG_TX, 0, "v_tx_applied");
      tick(8);
      up_tx = 1'b0;
      tick(4);
      up_tx = 1'b1;
      tick(4);
      up_tx = 1'b0;
      tick(6);
      up_tx = 1'b1;
      tick(4);
      up_tx = 1'b0;
      tick(2);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(2);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      up_en = 1'b0;
      tick(10);

      // re-arm during HOLD
      up_en = 1'b1;
      expect_at(7, SG_EN, 1, "r_en_e7");
      expect_at(10, SG_EN, 1, "r_en_e10");
      expect_at(11, SG_EN, 0, "r_fall_e11");
      expect_at(15, SG_BSY, 0, "r_busy_e15");
      expect_at(16, SG_BSY, 1, "r_busy_e16");
      expect_at(19, SG_EN, 0, "r_en_e19");
      expect_at(20, SG_EN, 1, "r_rerise_e20");
      tick(8);
      up_en = 1'b0;
      tick(3);
      up_en = 1'b1;
      tick(9);

      // saturation then asynchronous reset while enable is high
      for (int n = 0; n < 300; n++) begin
         up_tx = 1'b1;
         tick(2);
         up_tx = 1'b0;
         tick(2);
      end
      expect_at(4, SG_CNT, 255, "sat_cnt");
      expect_at(4, SG_FLG, 1, "sat_flag");
      expect_at(4, SG_EN, 1, "sat_en");
      expect_at(4, SG_TX, 0, "sat_tx");
      tick(4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_en", int'(enable), 0);
      chk("ar_tx", int'(txnrx), 0);
      chk("ar_busy", int'(busy), 0);
      chk("ar_flag", int'(viol_flag), 0);
      chk("ar_cnt", int'(viol_count), 0);
      up_en = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      chk("sb_left", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
